// File: rtl/alu_share_arbiter_pkg.sv
// Shared op-code encodings, FSM state type and the combinational core ALU
// used by the shared-ALU arbiter.
package alu_share_arbiter_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SLL   = 4'h5;
  localparam logic [3:0] OP_SRL   = 4'h6;
  localparam logic [3:0] OP_SRA   = 4'h7;
  localparam logic [3:0] OP_SLT   = 4'h8;
  localparam logic [3:0] OP_SLTU  = 4'h9;
  localparam logic [3:0] OP_PASSB = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

  function automatic logic aluIllegal(input logic [3:0] op);
    return op > OP_PASSB;
  endfunction

  // Codes B..F fall to the default arm and yield zero.
  function automatic logic [31:0] aluCompute(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] res;
    case (op)
      OP_ADD:   res = a + b;
      OP_SUB:   res = a - b;
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_SLL:   res = a << b[4:0];
      OP_SRL:   res = a >> b[4:0];
      OP_SRA:   res = $signed(a) >>> b[4:0];
      OP_SLT:   res = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU:  res = {31'b0, a < b};
      OP_PASSB: res = b;
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesters (master) and the shared-ALU
// arbiter (slave).
interface alu_share_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 32,
  parameter int IDW   = 1
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [4*N_REQ-1:0]     req_op;
  logic [WIDTH*N_REQ-1:0] req_a;
  logic [WIDTH*N_REQ-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_data;
  logic [IDW-1:0]         rsp_id;
  logic                   rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or above ptr, wrapping around.
// Outputs a one-hot grant and its binary index; all zero when disabled.
module rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  input  logic           i_en,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_idx
);

  logic w_found;
  int   w_j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (i_en && !w_found && i_req[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_idx      = IDW'(w_j);
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one 32-bit ALU between N_REQ requesters with round-robin grants and a
// single registered, ID-tagged response slot. WIDTH must be 32.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int WIDTH = 32,
  parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus
);

  state_t             r_state;
  state_t             w_nextState;
  logic [IDW-1:0]     r_rrPtr;
  logic [IDW-1:0]     r_idQ;
  logic [3:0]         r_opQ;
  logic [WIDTH-1:0]   r_aQ;
  logic [WIDTH-1:0]   r_bQ;
  logic [WIDTH-1:0]   r_rspData;
  logic [IDW-1:0]     r_rspId;
  logic               r_rspErr;

  logic               w_acceptEn;
  logic               w_grant;
  logic [N_REQ-1:0]   w_gnt;
  logic [IDW-1:0]     w_gntIdx;
  logic [IDW-1:0]     w_nextPtr;

  // Gating with rst_n keeps req_ready low while reset is held, even though
  // the state register already reads IDLE.
  assign w_acceptEn = rst_n & ((r_state == ST_IDLE) |
                               ((r_state == ST_RESP) & bus.rsp_ready));
  assign w_grant    = w_acceptEn & (|bus.req_valid);
  assign w_nextPtr  = (int'(w_gntIdx) == N_REQ - 1) ? '0 : w_gntIdx + 1'b1;

  rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_rr (
    .i_req (bus.req_valid),
    .i_ptr (r_rrPtr),
    .i_en  (w_acceptEn),
    .o_gnt (w_gnt),
    .o_idx (w_gntIdx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (w_grant) w_nextState = ST_EXEC;
      ST_EXEC: w_nextState = ST_RESP;
      ST_RESP: if (bus.rsp_ready) w_nextState = w_grant ? ST_EXEC : ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = w_gnt;
    bus.rsp_valid = (r_state == ST_RESP);
    bus.rsp_data  = r_rspData;
    bus.rsp_id    = r_rspId;
    bus.rsp_err   = r_rspErr;
  end

  // The ALU only ever sees the captured operands, never live requester inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr   <= '0;
      r_idQ     <= '0;
      r_opQ     <= '0;
      r_aQ      <= '0;
      r_bQ      <= '0;
      r_rspData <= '0;
      r_rspId   <= '0;
      r_rspErr  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_opQ   <= bus.req_op[4*w_gntIdx +: 4];
        r_aQ    <= bus.req_a[WIDTH*w_gntIdx +: WIDTH];
        r_bQ    <= bus.req_b[WIDTH*w_gntIdx +: WIDTH];
        r_idQ   <= w_gntIdx;
        r_rrPtr <= w_nextPtr;
      end
      if (r_state == ST_EXEC) begin
        r_rspData <= aluCompute(r_opQ, r_aQ, r_bQ);
        r_rspErr  <= aluIllegal(r_opQ);
        r_rspId   <= r_idQ;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a time-based reference model predicts
// grants and responses; a negedge monitor compares every cycle.
module tb_alu_share_arbiter;

  localparam int N   = 2;
  localparam int W   = 32;
  localparam int IDW = 1;

  typedef struct {
    logic [31:0] data;
    int          id;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.N_REQ(N), .WIDTH(W), .IDW(IDW)) bus ();

  alu_share_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic        vld [N];
  logic [3:0]  opR [N];
  logic [31:0] aR  [N];
  logic [31:0] bR  [N];
  logic        rspRdy;
  bit          grantedFlag [N];
  exp_t        expQ [$];
  int          dutGrantLog [$];
  int          cycleCnt = 0;
  bit          outstanding = 0;
  int          grantCycle = 0;
  int          ptr = 0;
  bit          randomMode = 0;
  int          issueBudget = 0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference ALU written from the op table with plain arithmetic.
  function automatic exp_t modelAlu(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input int id);
    exp_t e;
    logic [63:0] ext;
    int sh;
    sh = int'(b[4:0]);
    e.id = id;
    e.err = 1'b0;
    case (op)
      4'h0: e.data = a + b;
      4'h1: e.data = a - b;
      4'h2: e.data = a & b;
      4'h3: e.data = a | b;
      4'h4: e.data = a ^ b;
      4'h5: e.data = a << sh;
      4'h6: e.data = a >> sh;
      4'h7: begin ext = {{32{a[31]}}, a}; ext = ext >> sh; e.data = ext[31:0]; end
      4'h8: e.data = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'h9: e.data = (a < b) ? 32'd1 : 32'd0;
      4'hA: e.data = b;
      default: begin e.data = 32'd0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic driveBus();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]        = vld[i];
      bus.req_op[4*i +: 4]    = opR[i];
      bus.req_a[32*i +: 32]   = aR[i];
      bus.req_b[32*i +: 32]   = bR[i];
    end
    bus.rsp_ready = rspRdy;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (grantedFlag[i]) begin
        vld[i] = 1'b0;
        grantedFlag[i] = 1'b0;
      end
    end
    if (randomMode) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && issueBudget > 0 && $urandom_range(1, 0) == 1) begin
          vld[i] = 1'b1;
          opR[i] = 4'($urandom_range(15, 0));
          aR[i]  = $urandom;
          bR[i]  = ($urandom_range(1, 0) == 1) ? 32'($urandom_range(40, 0)) : $urandom;
          issueBudget--;
        end
      end
      rspRdy = ($urandom_range(3, 0) != 0);
    end
    driveBus();
  endtask

  task automatic applyStimulus(input int id, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    int n;
    vld[id] = 1'b1;
    opR[id] = op;
    aR[id]  = a;
    bR[id]  = b;
    driveBus();
    n = 0;
    while (vld[id] && n < 30) begin
      cycle();
      n++;
    end
    if (vld[id]) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_timeout requester=%0d actual=no_grant required=grant", id);
      vld[id] = 1'b0;
      driveBus();
    end
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while ((outstanding || vld[0] || vld[1]) && n < maxCycles) begin
      cycle();
      n++;
    end
    if (outstanding || vld[0] || vld[1]) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout actual=busy required=idle");
    end
  endtask

  // Monitor/scoreboard: accepts are allowed when nothing is outstanding or the
  // pending response is being consumed this cycle.
  always @(negedge clk) begin
    bit expValid;
    bit respFire;
    bit acceptOk;
    int g;
    int j;
    logic [N-1:0] expReady;
    if (!rst_n) begin
      expQ.delete();
      outstanding = 0;
      ptr = 0;
      for (int i = 0; i < N; i++) grantedFlag[i] = 0;
    end else begin
      expValid = outstanding && (cycleCnt >= grantCycle + 2);
      respFire = expValid && rspRdy;
      acceptOk = !outstanding || respFire;
      checkOutput("rsp_valid", bus.rsp_valid, expValid);
      if (expValid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rsp_unexpected actual=valid required=no_response");
        end else begin
          checkOutput("rsp_data", bus.rsp_data, expQ[0].data);
          checkOutput("rsp_id", bus.rsp_id, expQ[0].id);
          checkOutput("rsp_err", bus.rsp_err, expQ[0].err);
          if (respFire) begin
            void'(expQ.pop_front());
            outstanding = 0;
          end
        end
      end
      if (bus.req_ready[1]) dutGrantLog.push_back(1);
      else if (bus.req_ready[0]) dutGrantLog.push_back(0);
      g = -1;
      if (acceptOk) begin
        for (int k = 0; k < N; k++) begin
          j = (ptr + k) % N;
          if (vld[j] && g < 0) g = j;
        end
      end
      expReady = '0;
      if (g >= 0) expReady[g] = 1'b1;
      checkOutput("req_ready", bus.req_ready, expReady);
      if (g >= 0) begin
        expQ.push_back(modelAlu(opR[g], aR[g], bR[g], g));
        outstanding = 1;
        grantCycle = cycleCnt;
        ptr = (g + 1) % N;
        grantedFlag[g] = 1;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start;
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0; opR[i] = '0; aR[i] = '0; bR[i] = '0;
    end
    rspRdy = 1'b1;
    driveBus();

    // Reset state, with a pending request that must not be acknowledged.
    repeat (3) @(posedge clk);
    #1;
    vld[0] = 1'b1;
    driveBus();
    #1;
    checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
    checkOutput("reset_rsp_data", bus.rsp_data, 0);
    checkOutput("reset_rsp_id", bus.rsp_id, 0);
    checkOutput("reset_rsp_err", bus.rsp_err, 0);
    checkOutput("reset_req_ready", bus.req_ready, 0);
    vld[0] = 1'b0;
    driveBus();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset in the middle of EXEC drops the op silently.
    applyStimulus(0, 4'h0, 32'd5, 32'd7);
    vld[1] = 1'b1;
    opR[1] = 4'h1;
    driveBus();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midexec_rsp_valid", bus.rsp_valid, 0);
    checkOutput("midexec_req_ready", bus.req_ready, 0);
    vld[1] = 1'b0;
    driveBus();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fairness: both held valid, first grant after reset goes to requester 0.
    rspRdy = 1'b1;
    start = dutGrantLog.size();
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b1; opR[i] = 4'h0; aR[i] = $urandom; bR[i] = $urandom;
    end
    driveBus();
    for (int c = 0; c < 9; c++) begin
      cycle();
      for (int i = 0; i < N; i++) begin
        if (!vld[i]) begin
          vld[i] = 1'b1; opR[i] = 4'($urandom_range(10, 0)); aR[i] = $urandom; bR[i] = $urandom;
        end
      end
      driveBus();
    end
    for (int i = 0; i < N; i++) vld[i] = 1'b0;
    driveBus();
    waitDrain(20);
    for (int k = 0; k < 4; k++) begin
      if (dutGrantLog.size() > start + k)
        checkOutput("fair_order", dutGrantLog[start + k], k % 2);
      else begin
        checks++;
        errors++;
        $display("[TB] FAIL fair_order actual=missing required=%0d", k % 2);
      end
    end

    // Single ADD wrapping to zero.
    applyStimulus(0, 4'h0, 32'hFFFFFFFF, 32'd1);
    cycle();
    checkOutput("add_valid", bus.rsp_valid, 1);
    checkOutput("add_data", bus.rsp_data, 32'h0);
    checkOutput("add_id", bus.rsp_id, 0);
    checkOutput("add_err", bus.rsp_err, 0);
    waitDrain(10);

    // Backpressure on SRA with a competing request held off.
    rspRdy = 1'b0;
    driveBus();
    applyStimulus(0, 4'h7, 32'h80000000, 32'd4);
    vld[1] = 1'b1; opR[1] = 4'h2; aR[1] = 32'hF0F0F0F0; bR[1] = 32'h0FF00FF0;
    driveBus();
    repeat (6) cycle();
    checkOutput("bp_data", bus.rsp_data, 32'hF8000000);
    checkOutput("bp_req_ready", bus.req_ready, 0);
    rspRdy = 1'b1;
    driveBus();
    waitDrain(10);

    // Illegal op from requester 1.
    applyStimulus(1, 4'hC, 32'h12345678, 32'h9ABCDEF0);
    cycle();
    checkOutput("ill_err", bus.rsp_err, 1);
    checkOutput("ill_data", bus.rsp_data, 0);
    checkOutput("ill_id", bus.rsp_id, 1);
    waitDrain(10);

    // Signed vs unsigned compare with the same operands.
    applyStimulus(1, 4'h8, 32'hFFFFFFFF, 32'd1);
    cycle();
    checkOutput("slt_data", bus.rsp_data, 1);
    waitDrain(10);
    applyStimulus(1, 4'h9, 32'hFFFFFFFF, 32'd1);
    cycle();
    checkOutput("sltu_data", bus.rsp_data, 0);
    waitDrain(10);

    // Randomized traffic with random response backpressure.
    issueBudget = 200;
    randomMode = 1;
    while (issueBudget > 0) cycle();
    randomMode = 0;
    rspRdy = 1'b1;
    driveBus();
    waitDrain(200);
    repeat (3) cycle();
    checkOutput("queue_empty", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
